pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazard classes:
  - load-use data hazards, detected from the ID register fields and the EX stage destination;
  - taken-branch/jump redirects resolved in EX;
  - multi-cycle multiply/divide ops occupying EX for MD_LAT cycles, sequenced by an internal FSM and counter.

---
 rtl/pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl
// ----------------------------------------------------------------------------
// Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the
// hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers and
// resolves three hazard classes:
//   * load-use data hazards (ID source registers against the EX load target),
//   * taken branch / jump redirects resolved in EX,
//   * multi-cycle mul/div ops that occupy EX for MD_LAT cycles.
//
// Parameters:
//   MD_LAT  total EX occupancy of a mul/div op in cycles (2..16)
//   CNT_W   width of the mul/div down-counter (2^CNT_W >= MD_LAT-1)
//
// Ports:
//   CLK             clock, rising edge
//   Reset           synchronous, active-high reset; forces all outputs to 0
//   ID_Ra / ID_Rb   rs1 / rs2 of the instruction entering ID
//   ID_UseRa/UseRb  ID instruction actually reads rs1 / rs2
//   EX_MemRead      instruction in EX is a load
//   EX_Rd           destination register of the EX instruction
//   EX_BranchTaken  EX resolved a taken branch or jump
//   EX_MdStart      EX holds a mul/div op in its first EX cycle
//   PC_Hold         hold the PC
//   IFID_Hold       hold IF/ID (1 = hold)
//   IFID_Flush      load a NOP into IF/ID
//   IDEX_Hold       hold ID/EX
//   IDEX_Flush      load a bubble into ID/EX
//   EXMEM_Bubble    load a bubble into EX/MEM
//   MD_Busy         sequencer is in the MD_BUSY state
//   MD_Done         one-cycle pulse in the last EX cycle of a mul/div op
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   Stall_Cnt       saturating count of cycles with PC_Hold=1
//   Flush_Cnt       saturating count of cycles with IFID_Flush=1
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       ID_Ra,
    input  logic [4:0]       ID_Rb,
    input  logic             ID_UseRa,
    input  logic             ID_UseRb,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_BranchTaken,
    input  logic             EX_MdStart,
    output logic             PC_Hold,
    output logic             IFID_Hold,
    output logic             IFID_Flush,
    output logic             IDEX_Hold,
    output logic             IDEX_Flush,
    output logic             EXMEM_Bubble,
    output logic             MD_Busy,
    output logic             MD_Done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      Stall_Cnt,
    output logic [31:0]      Flush_Cnt
`endif
);

    // Catch illegal parameter combinations at elaboration time.
    if ((MD_LAT < 2) || (MD_LAT > 16)) begin : g_bad_md_lat
        $error("pipeline_hazard_ctrl: MD_LAT must be in 2..16");
    end
    if ((1 << CNT_W) < (MD_LAT - 1)) begin : g_bad_cnt_w
        $error("pipeline_hazard_ctrl: CNT_W too narrow for MD_LAT");
    end

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               load_use;

    // A load in EX whose target is read by the ID instruction must be
    // separated by one bubble. x0 is hard-wired to zero, so it never
    // creates a real dependency.
    assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                      ((ID_UseRa && (EX_Rd == ID_Ra)) ||
                       (ID_UseRb && (EX_Rd == ID_Rb)));

    // State register. The counter is loaded with MD_LAT-2 on a start so that
    // it reaches zero in the last of the MD_LAT-1 busy cycles.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and output decode. Everything stays at 0 while Reset is
    // high; the mul/div sequence outranks every other hazard, then a new
    // mul/div start, then a branch redirect, then a load-use stall.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        PC_Hold      = 1'b0;
        IFID_Hold    = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Hold    = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Bubble = 1'b0;
        MD_Busy      = 1'b0;
        MD_Done      = 1'b0;

        if (!Reset) begin
            unique case (state)
                RUN: begin
                    if (EX_MdStart) begin
                        PC_Hold      = 1'b1;
                        IFID_Hold    = 1'b1;
                        IDEX_Hold    = 1'b1;
                        EXMEM_Bubble = 1'b1;
                        state_nxt    = MD_BUSY;
                        cnt_nxt      = CNT_W'(MD_LAT - 2);
                    end else if (EX_BranchTaken) begin
                        // The wrong-path instructions in IF/ID and ID/EX are
                        // squashed; the PC itself is redirected by EX.
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (load_use) begin
                        PC_Hold    = 1'b1;
                        IFID_Hold  = 1'b1;
                        IDEX_Flush = 1'b1;
                    end
                end

                MD_BUSY: begin
                    PC_Hold      = 1'b1;
                    IFID_Hold    = 1'b1;
                    IDEX_Hold    = 1'b1;
                    EXMEM_Bubble = 1'b1;
                    MD_Busy      = 1'b1;
                    if (cnt == '0) begin
                        // Last EX cycle: the result enters EX/MEM on the
                        // following edge, when we are back in RUN.
                        MD_Done   = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters: one tick per stalled cycle and per flushed
    // cycle, sticking at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (PC_Hold && (Stall_Cnt != 32'hFFFF_FFFF)) begin
                Stall_Cnt <= Stall_Cnt + 32'd1;
            end
            if (IFID_Flush && (Flush_Cnt != 32'hFFFF_FFFF)) begin
                Flush_Cnt <= Flush_Cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for pipeline_hazard_ctrl. A behavioural model that
// tracks "mul/div cycles still to go" predicts every output on every cycle;
// directed sequences with literal expectations pin that model down, then a
// long randomized run exercises the priority mix.
// Define HAZARD_PERF_CNT_EN to also check Stall_Cnt / Flush_Cnt.
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    // Output vector order:
    // {PC_Hold, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Flush, EXMEM_Bubble, MD_Busy, MD_Done}
    localparam logic [7:0] OUT_IDLE  = 8'b0000_0000;
    localparam logic [7:0] OUT_START = 8'b1101_0100;
    localparam logic [7:0] OUT_BUSY  = 8'b1101_0110;
    localparam logic [7:0] OUT_DONE  = 8'b1101_0111;
    localparam logic [7:0] OUT_LU    = 8'b1100_1000;
    localparam logic [7:0] OUT_BR    = 8'b0010_1000;

    logic        CLK;
    logic        Reset;
    logic [4:0]  ID_Ra;
    logic [4:0]  ID_Rb;
    logic        ID_UseRa;
    logic        ID_UseRb;
    logic        EX_MemRead;
    logic [4:0]  EX_Rd;
    logic        EX_BranchTaken;
    logic        EX_MdStart;
    logic        PC_Hold;
    logic        IFID_Hold;
    logic        IFID_Flush;
    logic        IDEX_Hold;
    logic        IDEX_Flush;
    logic        EXMEM_Bubble;
    logic        MD_Busy;
    logic        MD_Done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Cnt;
    logic [31:0] Flush_Cnt;
`endif

    logic [7:0]  out_vec;
    int          checks;
    int          errors;
    logic        check_en;

    // Model state: number of MD_BUSY cycles still ahead, and event counts.
    int          md_left;
    longint      stall_model;
    longint      flush_model;
    int          cyc;

    assign out_vec = {PC_Hold, IFID_Hold, IFID_Flush, IDEX_Hold,
                      IDEX_Flush, EXMEM_Bubble, MD_Busy, MD_Done};

    pipeline_hazard_ctrl #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ID_Ra          (ID_Ra),
        .ID_Rb          (ID_Rb),
        .ID_UseRa       (ID_UseRa),
        .ID_UseRb       (ID_UseRb),
        .EX_MemRead     (EX_MemRead),
        .EX_Rd          (EX_Rd),
        .EX_BranchTaken (EX_BranchTaken),
        .EX_MdStart     (EX_MdStart),
        .PC_Hold        (PC_Hold),
        .IFID_Hold      (IFID_Hold),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Hold      (IDEX_Hold),
        .IDEX_Flush     (IDEX_Flush),
        .EXMEM_Bubble   (EXMEM_Bubble),
        .MD_Busy        (MD_Busy),
        .MD_Done        (MD_Done)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Stall_Cnt      (Stall_Cnt),
        .Flush_Cnt      (Flush_Cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic md,
                                 input logic br, input logic memrd,
                                 input logic [4:0] rd, input logic [4:0] ra,
                                 input logic ura, input logic [4:0] rb,
                                 input logic urb);
        Reset          = rst;
        EX_MdStart     = md;
        EX_BranchTaken = br;
        EX_MemRead     = memrd;
        EX_Rd          = rd;
        ID_Ra          = ra;
        ID_UseRa       = ura;
        ID_Rb          = rb;
        ID_UseRb       = urb;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic applyMdStart();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    // Literal check of the output vector shortly after inputs settle.
    task automatic expectNow(input string name, input logic [7:0] exp);
        #1;
        checkOutput(name, {24'd0, out_vec}, {24'd0, exp});
    endtask

    // Reference behaviour from the hazard rules, in terms of how many busy
    // cycles of a mul/div op remain rather than any FSM encoding.
    function automatic logic [7:0] modelOutputs();
        logic lu;
        lu = EX_MemRead && (EX_Rd != 5'd0) &&
             ((ID_UseRa && (EX_Rd == ID_Ra)) || (ID_UseRb && (EX_Rd == ID_Rb)));
        if (Reset)               return OUT_IDLE;
        if (md_left > 0)         return (md_left == 1) ? OUT_DONE : OUT_BUSY;
        if (EX_MdStart)          return OUT_START;
        if (EX_BranchTaken)      return OUT_BR;
        if (lu)                  return OUT_LU;
        return OUT_IDLE;
    endfunction

    // Compare process: runs on the falling edge, checks the DUT against the
    // model, then advances the model across the coming rising edge.
    always @(negedge CLK) begin
        logic [7:0] exp;
        if (check_en) begin
            exp = modelOutputs();
            checkOutput($sformatf("cycle %0d outputs", cyc),
                        {24'd0, out_vec}, {24'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
            checkOutput($sformatf("cycle %0d Stall_Cnt", cyc), Stall_Cnt,
                        32'(stall_model));
            checkOutput($sformatf("cycle %0d Flush_Cnt", cyc), Flush_Cnt,
                        32'(flush_model));
`endif
            if (Reset) begin
                md_left     = 0;
                stall_model = 0;
                flush_model = 0;
            end else begin
                if (exp[7] && stall_model < 64'hFFFF_FFFF) stall_model++;
                if (exp[5] && flush_model < 64'hFFFF_FFFF) flush_model++;
                if (md_left > 0)     md_left--;
                else if (EX_MdStart) md_left = MD_LAT - 1;
            end
            cyc++;
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        md_left     = 0;
        stall_model = 0;
        flush_model = 0;
        cyc         = 0;
        check_en    = 1'b1;

        // Reset held for two cycles with a mul/div start pending.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        expectNow("reset cycle 0", OUT_IDLE);
        nextCycle();
        expectNow("reset cycle 1", OUT_IDLE);
        nextCycle();
        applyIdle();
        expectNow("after reset", OUT_IDLE);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("Stall_Cnt after reset", Stall_Cnt, 32'd0);
`endif

        // Load-use on rs1, then the load moves on.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        expectNow("load-use rs1", OUT_LU);
        nextCycle();
        applyIdle();
        expectNow("load-use cleared", OUT_IDLE);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        expectNow("load-use rs1 unused", OUT_IDLE);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        expectNow("load-use x0", OUT_IDLE);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
        expectNow("load-use rs2", OUT_LU);

        // Branch wins over a simultaneous load-use.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        expectNow("branch over load-use", OUT_BR);
        nextCycle();
        applyIdle();
        expectNow("after branch", OUT_IDLE);

        // Single mul/div, branch in the middle is ignored.
        nextCycle();
        applyMdStart();
        expectNow("md t", OUT_START);
        nextCycle();
        applyIdle();
        expectNow("md t+1", OUT_BUSY);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        expectNow("md t+2 branch ignored", OUT_BUSY);
        nextCycle();
        applyIdle();
        expectNow("md t+3 done", OUT_DONE);
        nextCycle();
        expectNow("md t+4 run", OUT_IDLE);

        // Back-to-back mul/div with no dead cycle.
        nextCycle();
        applyMdStart();
        expectNow("b2b t", OUT_START);
        nextCycle();
        applyIdle();
        expectNow("b2b t+1", OUT_BUSY);
        nextCycle();
        expectNow("b2b t+2", OUT_BUSY);
        nextCycle();
        expectNow("b2b t+3 done", OUT_DONE);
        nextCycle();
        applyMdStart();
        expectNow("b2b t+4 restart", OUT_START);
        nextCycle();
        applyIdle();
        expectNow("b2b t+5", OUT_BUSY);
        nextCycle();
        expectNow("b2b t+6", OUT_BUSY);
        nextCycle();
        expectNow("b2b t+7 done", OUT_DONE);
        nextCycle();
        expectNow("b2b t+8 run", OUT_IDLE);

        // Load-use held behind a mul/div surfaces in the first RUN cycle.
        nextCycle();
        applyMdStart();
        expectNow("md+lu t", OUT_START);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        expectNow("md+lu t+1", OUT_BUSY);
        nextCycle();
        expectNow("md+lu t+2", OUT_BUSY);
        nextCycle();
        expectNow("md+lu t+3", OUT_DONE);
        nextCycle();
        expectNow("md+lu t+4 stall", OUT_LU);

        // Reset aborts a running mul/div.
        nextCycle();
        applyMdStart();
        expectNow("abort t", OUT_START);
        nextCycle();
        applyIdle();
        expectNow("abort t+1", OUT_BUSY);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        expectNow("abort t+2 reset", OUT_IDLE);
        nextCycle();
        applyIdle();
        expectNow("abort t+3 no done", OUT_IDLE);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("Stall_Cnt cleared", Stall_Cnt, 32'd0);
        checkOutput("Flush_Cnt cleared", Flush_Cnt, 32'd0);
        nextCycle();
        applyMdStart();
        nextCycle();
        applyIdle();
        nextCycle();
        nextCycle();
        nextCycle();
        expectNow("perf md run", OUT_IDLE);
        checkOutput("Stall_Cnt after md", Stall_Cnt, 32'd4);
`endif

        // Randomized mix, small register range to make matches frequent.
        repeat (3000) begin
            nextCycle();
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
